// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the BRAM arbiter slice: FSM state encoding,
// requester IDs and default data/address widths.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_t;

    // Requester IDs as stored in the owner and last_grant registers
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int DEF_DATA_BITS = 16;
    localparam int DEF_ADDR_BITS = 8;

endpackage

// File: rtl/arb_grant2.sv
// Two-way grant for the BRAM arbiter.
// Build option ARB_ROUND_ROBIN_EN: when defined, a tie goes to the requester
// that did not win last time; when undefined, M0 always wins a tie.
module arb_grant2
    import mem_ctrl_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    output logic grant0,
    output logic grant1
);

    logic last_grant;

    // Remember the most recent winner; reset to M1 so M0 wins the first tie
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_grant <= M1;
        end else if (accept) begin
            last_grant <= grant1 ? M1 : M0;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Alternate on ties, otherwise grant whichever requester is asking
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (valid0 && valid1) begin
            if (last_grant == M1) grant0 = 1'b1;
            else                  grant1 = 1'b1;
        end else begin
            grant0 = valid0;
            grant1 = valid1;
        end
    end
`else
    // Fixed priority: the host (M0) always wins; M1 may starve by design
    assign grant0 = valid0;
    assign grant1 = valid1 & ~valid0;

    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/bram_arbiter.sv
// Shares one BRAM bank port between the UART command controller (M0) and an
// on-chip requester (M1). Each access runs as accept -> issue -> (wait) ->
// response, and read data goes back to the owning requester only.
// Tie-break policy is selected by ARB_ROUND_ROBIN_EN (see arb_grant2).
//
// Handshake: a requester raises req_valid and holds req_* stable until it
// sees req_ready; ready is combinational, asserted only in IDLE for the
// winning requester, and the request is taken on the clock edge where
// valid && ready. Completion is a one-cycle rsp_valid pulse to the owner,
// with rsp_rdata valid alongside it (0 for writes).
module bram_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int NUM_BLOCKS = 16,
    parameter int SEL_BITS   = $clog2(NUM_BLOCKS),
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int RD_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          m0_req_valid,
    output logic                          m0_req_ready,
    input  logic                          m0_req_we,
    input  logic [SEL_BITS+ADDR_BITS-1:0] m0_req_addr,
    input  logic [DATA_BITS-1:0]          m0_req_wdata,
    output logic                          m0_rsp_valid,
    output logic [DATA_BITS-1:0]          m0_rsp_rdata,
    input  logic                          m1_req_valid,
    output logic                          m1_req_ready,
    input  logic                          m1_req_we,
    input  logic [SEL_BITS+ADDR_BITS-1:0] m1_req_addr,
    input  logic [DATA_BITS-1:0]          m1_req_wdata,
    output logic                          m1_rsp_valid,
    output logic [DATA_BITS-1:0]          m1_rsp_rdata,
    output logic                          mem_rd_en,
    output logic                          mem_wr_en,
    output logic [SEL_BITS+ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0]          mem_wdata,
    input  logic [DATA_BITS-1:0]          mem_rdata,
    output logic                          busy,
    output logic                          err_oob,
    output state_t                        dbg_state
);

    localparam int AW = SEL_BITS + ADDR_BITS;
    // One extra bit so NUM_BLOCKS itself is representable for the compare
    localparam logic [SEL_BITS:0] BLOCK_LIMIT = (SEL_BITS + 1)'(NUM_BLOCKS);
    localparam logic [2:0]        WAIT_INIT   = 3'(RD_LATENCY - 1);

    state_t         state;
    logic           owner;
    logic           op_we;
    logic           op_oob;
    logic [2:0]     wait_cnt;

    logic           grant0;
    logic           grant1;
    logic           accept;

    logic           sel_we;
    logic [AW-1:0]  sel_addr;
    logic [DATA_BITS-1:0] sel_wdata;
    logic           sel_oob;
    logic [DATA_BITS-1:0] rd_capture;

    arb_grant2 u_grant (
        .clk    (clk),
        .resetn (resetn),
        .valid0 (m0_req_valid),
        .valid1 (m1_req_valid),
        .accept (accept),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign m0_req_ready = (state == IDLE) & grant0;
    assign m1_req_ready = (state == IDLE) & grant1;
    assign accept       = m0_req_ready | m1_req_ready;
    assign dbg_state    = state;

    // Out-of-range blocks return zero instead of whatever the bus holds
    assign rd_capture = op_oob ? '0 : mem_rdata;

    // Select the winning request and flag selects beyond the populated blocks
    always_comb begin
        sel_we    = m0_req_we;
        sel_addr  = m0_req_addr;
        sel_wdata = m0_req_wdata;
        if (m1_req_ready) begin
            sel_we    = m1_req_we;
            sel_addr  = m1_req_addr;
            sel_wdata = m1_req_wdata;
        end
        sel_oob = ({1'b0, sel_addr[AW-1 -: SEL_BITS]} >= BLOCK_LIMIT);
    end

    // Transaction FSM with registered memory strobes and response outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            owner        <= M0;
            op_we        <= 1'b0;
            op_oob       <= 1'b0;
            wait_cnt     <= '0;
            mem_rd_en    <= 1'b0;
            mem_wr_en    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            m0_rsp_valid <= 1'b0;
            m0_rsp_rdata <= '0;
            m1_rsp_valid <= 1'b0;
            m1_rsp_rdata <= '0;
            busy         <= 1'b0;
            err_oob      <= 1'b0;
        end else begin
            mem_rd_en    <= 1'b0;
            mem_wr_en    <= 1'b0;
            m0_rsp_valid <= 1'b0;
            m1_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner  <= m1_req_ready ? M1 : M0;
                        op_we  <= sel_we;
                        op_oob <= sel_oob;
                        busy   <= 1'b1;
                        state  <= ISSUE;
                        // Strobes are registered here so they are high
                        // exactly during the ISSUE cycle
                        if (sel_oob) begin
                            err_oob <= 1'b1;
                        end else begin
                            mem_addr <= sel_addr;
                            if (sel_we) begin
                                mem_wr_en <= 1'b1;
                                mem_wdata <= sel_wdata;
                            end else begin
                                mem_rd_en <= 1'b1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (op_we) begin
                        state <= RESP;
                        if (owner == M1) begin
                            m1_rsp_valid <= 1'b1;
                            m1_rsp_rdata <= '0;
                        end else begin
                            m0_rsp_valid <= 1'b1;
                            m0_rsp_rdata <= '0;
                        end
                    end else begin
                        wait_cnt <= WAIT_INIT;
                        state    <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (wait_cnt == 3'd0) begin
                        state <= RESP;
                        if (owner == M1) begin
                            m1_rsp_valid <= 1'b1;
                            m1_rsp_rdata <= rd_capture;
                        end else begin
                            m0_rsp_valid <= 1'b1;
                            m0_rsp_rdata <= rd_capture;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter. Instance 0 uses the default build
// (16 blocks, read latency 1); instance 1 uses 12 blocks and read latency 3.
module tb_bram_arbiter;
    import mem_ctrl_pkg::*;

    logic clk;
    logic resetn;

    logic        m0_req_valid [2];
    logic        m0_req_ready [2];
    logic        m0_req_we    [2];
    logic [11:0] m0_req_addr  [2];
    logic [15:0] m0_req_wdata [2];
    logic        m0_rsp_valid [2];
    logic [15:0] m0_rsp_rdata [2];
    logic        m1_req_valid [2];
    logic        m1_req_ready [2];
    logic        m1_req_we    [2];
    logic [11:0] m1_req_addr  [2];
    logic [15:0] m1_req_wdata [2];
    logic        m1_rsp_valid [2];
    logic [15:0] m1_rsp_rdata [2];
    logic        mem_rd_en    [2];
    logic        mem_wr_en    [2];
    logic [11:0] mem_addr     [2];
    logic [15:0] mem_wdata    [2];
    logic        busy         [2];
    logic        err_oob      [2];
    state_t      dbg_state    [2];
    logic [15:0] rd0;
    logic [15:0] rd1;

    logic [15:0] bram0 [0:4095];
    logic [15:0] bram1 [0:4095];
    logic [15:0] p1_0, p1_1, p1_2;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    bram_arbiter u_dut0 (
        .clk(clk), .resetn(resetn),
        .m0_req_valid(m0_req_valid[0]), .m0_req_ready(m0_req_ready[0]),
        .m0_req_we(m0_req_we[0]), .m0_req_addr(m0_req_addr[0]),
        .m0_req_wdata(m0_req_wdata[0]), .m0_rsp_valid(m0_rsp_valid[0]),
        .m0_rsp_rdata(m0_rsp_rdata[0]),
        .m1_req_valid(m1_req_valid[0]), .m1_req_ready(m1_req_ready[0]),
        .m1_req_we(m1_req_we[0]), .m1_req_addr(m1_req_addr[0]),
        .m1_req_wdata(m1_req_wdata[0]), .m1_rsp_valid(m1_rsp_valid[0]),
        .m1_rsp_rdata(m1_rsp_rdata[0]),
        .mem_rd_en(mem_rd_en[0]), .mem_wr_en(mem_wr_en[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(rd0),
        .busy(busy[0]), .err_oob(err_oob[0]), .dbg_state(dbg_state[0])
    );

    bram_arbiter #(.NUM_BLOCKS(12), .RD_LATENCY(3)) u_dut1 (
        .clk(clk), .resetn(resetn),
        .m0_req_valid(m0_req_valid[1]), .m0_req_ready(m0_req_ready[1]),
        .m0_req_we(m0_req_we[1]), .m0_req_addr(m0_req_addr[1]),
        .m0_req_wdata(m0_req_wdata[1]), .m0_rsp_valid(m0_rsp_valid[1]),
        .m0_rsp_rdata(m0_rsp_rdata[1]),
        .m1_req_valid(m1_req_valid[1]), .m1_req_ready(m1_req_ready[1]),
        .m1_req_we(m1_req_we[1]), .m1_req_addr(m1_req_addr[1]),
        .m1_req_wdata(m1_req_wdata[1]), .m1_rsp_valid(m1_rsp_valid[1]),
        .m1_rsp_rdata(m1_rsp_rdata[1]),
        .mem_rd_en(mem_rd_en[1]), .mem_wr_en(mem_wr_en[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(rd1),
        .busy(busy[1]), .err_oob(err_oob[1]), .dbg_state(dbg_state[1])
    );

    // BRAM models: latency 1 for instance 0, a 3-stage pipe for instance 1
    // that yields zero unless a read was actually strobed 3 cycles earlier
    always @(posedge clk) begin
        if (mem_wr_en[0]) bram0[mem_addr[0]] <= mem_wdata[0];
        if (mem_rd_en[0]) rd0 <= bram0[mem_addr[0]];
    end

    always @(posedge clk) begin
        p1_0 <= mem_rd_en[1] ? bram1[mem_addr[1]] : 16'h0000;
        p1_1 <= p1_0;
        p1_2 <= p1_1;
    end
    assign rd1 = p1_2;

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_req(input int d, input int who, input logic v, input logic we,
                             input logic [11:0] addr, input logic [15:0] wdata);
        if (who == 0) begin
            m0_req_valid[d] = v; m0_req_we[d] = we;
            m0_req_addr[d] = addr; m0_req_wdata[d] = wdata;
        end else begin
            m1_req_valid[d] = v; m1_req_we[d] = we;
            m1_req_addr[d] = addr; m1_req_wdata[d] = wdata;
        end
    endtask

    function automatic logic ready_of(input int d, input int who);
        return (who == 0) ? m0_req_ready[d] : m1_req_ready[d];
    endfunction

    // Issue one request and observe it through to its response pulse.
    // Cycle c counts cycles after the acceptance edge (c = 1 is the first).
    task automatic do_req(input int d, input int who, input logic we,
                          input logic [11:0] addr, input logic [15:0] wdata,
                          output int acc_wait, output int rsp_lat,
                          output int rd_cnt, output int wr_cnt, output int en_first,
                          output logic [15:0] rdata, output int other_cnt);
        drive_req(d, who, 1'b1, we, addr, wdata);
        #1;
        acc_wait = 0;
        while (!ready_of(d, who) && acc_wait < 20) begin
            @(posedge clk); #1;
            acc_wait++;
        end
        @(posedge clk); #1;
        drive_req(d, who, 1'b0, 1'b0, 12'h000, 16'h0000);
        rsp_lat = -1; rd_cnt = 0; wr_cnt = 0; en_first = -1; other_cnt = 0;
        rdata = 16'hxxxx;
        for (int c = 1; c <= 12; c++) begin
            if (mem_rd_en[d]) rd_cnt++;
            if (mem_wr_en[d]) wr_cnt++;
            if ((mem_rd_en[d] || mem_wr_en[d]) && en_first < 0) en_first = c;
            if (who == 0 ? m1_rsp_valid[d] : m0_rsp_valid[d]) other_cnt++;
            if (who == 0 ? m0_rsp_valid[d] : m1_rsp_valid[d]) begin
                rsp_lat = c;
                rdata = (who == 0) ? m0_rsp_rdata[d] : m1_rsp_rdata[d];
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    // ---------------- stimulus ----------------
    int acc_wait, rsp_lat, rd_cnt, wr_cnt, en_first, other_cnt, grants, cyc, pulses;
    logic [15:0] rdata;
    logic [1:0] got_grant;

    initial begin
        for (int d = 0; d < 2; d++) begin
            drive_req(d, 0, 1'b0, 1'b0, 12'h000, 16'h0000);
            drive_req(d, 1, 1'b0, 1'b0, 12'h000, 16'h0000);
        end
        bram1[12'hC05] = 16'h1234;
        bram1[12'h2A7] = 16'hA5C3;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        for (int d = 0; d < 2; d++) begin
            check("rst_state", dbg_state[d], IDLE);
            check("rst_busy", busy[d], 1'b0);
            check("rst_err_oob", err_oob[d], 1'b0);
            check("rst_strobes", {mem_rd_en[d], mem_wr_en[d]}, 2'b00);
            check("rst_addr_wdata", {mem_addr[d], mem_wdata[d]}, 28'h0);
            check("rst_rsp", {m0_rsp_valid[d], m1_rsp_valid[d], m0_rsp_rdata[d], m1_rsp_rdata[d]}, 34'h0);
        end
        resetn = 1'b1;
        @(posedge clk); #1;

        // M0 write 0x310 <= BEEF
        do_req(0, 0, 1'b1, 12'h310, 16'hBEEF, acc_wait, rsp_lat, rd_cnt, wr_cnt, en_first, rdata, other_cnt);
        check("wr_accept_wait", acc_wait, 0);
        check("wr_strobe_cycle", en_first, 1);
        check("wr_strobe_count", {rd_cnt[7:0], wr_cnt[7:0]}, 16'h0001);
        check("wr_rsp_latency", rsp_lat, 2);
        check("wr_rsp_rdata", rdata, 16'h0000);
        check("wr_other_rsp", other_cnt, 0);
        check("wr_mem_addr_hold", mem_addr[0], 12'h310);
        check("wr_mem_wdata_hold", mem_wdata[0], 16'hBEEF);
        check("wr_bram_content", bram0[12'h310], 16'hBEEF);

        // M1 read of 0x310, back to back
        do_req(0, 1, 1'b0, 12'h310, 16'h0000, acc_wait, rsp_lat, rd_cnt, wr_cnt, en_first, rdata, other_cnt);
        check("rd_accept_wait", acc_wait, 1);
        check("rd_strobe_cycle", en_first, 1);
        check("rd_strobe_count", {rd_cnt[7:0], wr_cnt[7:0]}, 16'h0100);
        check("rd_rsp_latency", rsp_lat, 3);
        check("rd_rsp_rdata", rdata, 16'hBEEF);
        check("rd_m0_quiet", other_cnt, 0);
        check("rd_m0_rdata_held", m0_rsp_rdata[0], 16'h0000);
        @(posedge clk); #1;
        check("rd_busy_after", busy[0], 1'b0);

        // Both requesters hold valid for 4 transactions
`ifdef ARB_ROUND_ROBIN_EN
        exp_q = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
        exp_q = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
        drive_req(0, 0, 1'b1, 1'b1, 12'h001, 16'h1111);
        drive_req(0, 1, 1'b1, 1'b1, 12'h002, 16'h2222);
        #1;
        grants = 0;
        cyc = 0;
        while (grants < 4 && cyc < 40) begin
            if (m0_req_ready[0] || m1_req_ready[0]) begin
                check("arb_single_ready", m0_req_ready[0] & m1_req_ready[0], 1'b0);
                got_grant = m1_req_ready[0] ? 2'd1 : 2'd0;
                check("arb_grant", got_grant, exp_q.pop_front());
                grants++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        drive_req(0, 0, 1'b0, 1'b0, 12'h000, 16'h0000);
        drive_req(0, 1, 1'b0, 1'b0, 12'h000, 16'h0000);
        check("arb_grant_total", grants, 4);
        repeat (4) @(posedge clk);
        #1;
        check("arb_idle_after", dbg_state[0], IDLE);

        // Reset while a read sits in WAIT_RD
        drive_req(0, 1, 1'b1, 1'b0, 12'h310, 16'h0000);
        #1;
        cyc = 0;
        while (!m1_req_ready[0] && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        drive_req(0, 1, 1'b0, 1'b0, 12'h000, 16'h0000);
        @(posedge clk); #1;
        check("rst_mid_in_wait", dbg_state[0], WAIT_RD);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_busy", busy[0], 1'b0);
        check("rst_mid_state", dbg_state[0], IDLE);
        pulses = int'(m0_rsp_valid[0]) + int'(m1_rsp_valid[0]);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            pulses += int'(m0_rsp_valid[0]) + int'(m1_rsp_valid[0]);
        end
        check("rst_mid_no_rsp", pulses, 0);
        do_req(0, 0, 1'b0, 12'h310, 16'h0000, acc_wait, rsp_lat, rd_cnt, wr_cnt, en_first, rdata, other_cnt);
        check("rst_mid_next_accept", acc_wait, 0);
        check("rst_mid_next_rdata", rdata, 16'hBEEF);

        // 12-block, latency-3 instance: out-of-range select 0xC
        @(posedge clk); #1;
        do_req(1, 0, 1'b0, 12'hC05, 16'h0000, acc_wait, rsp_lat, rd_cnt, wr_cnt, en_first, rdata, other_cnt);
        check("oob_accept_wait", acc_wait, 0);
        check("oob_no_strobe", rd_cnt + wr_cnt, 0);
        check("oob_rsp_latency", rsp_lat, 5);
        check("oob_rsp_rdata", rdata, 16'h0000);
        check("oob_err_set", err_oob[1], 1'b1);

        // In-range read right after: response at RD_LATENCY+2, next
        // acceptance one cycle later (3+RD_LATENCY edge to edge)
        do_req(1, 0, 1'b0, 12'h2A7, 16'h0000, acc_wait, rsp_lat, rd_cnt, wr_cnt, en_first, rdata, other_cnt);
        check("lat3_accept_wait", acc_wait, 1);
        check("lat3_strobe", {rd_cnt[7:0], en_first[7:0]}, 16'h0101);
        check("lat3_rsp_latency", rsp_lat, 5);
        check("lat3_rsp_rdata", rdata, 16'hA5C3);
        check("oob_err_sticky", err_oob[1], 1'b1);

        resetn = 1'b0;
        @(posedge clk); #1;
        check("oob_err_cleared", err_oob[1], 1'b0);
        resetn = 1'b1;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
